tagged_port_serializer: RTL and testbench

//   Transmit end of the narrow tagged-port link: takes one wide tagged word (tag + packed data)
//   per valid/ready handshake and drives it out as a framed sequence of LANE_W-bit beats.

---
 rtl/tagged_port_serializer.sv | 148 ++++++++++++++
 tb/tb_tagged_port_serializer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/tagged_port_serializer.sv
// tagged_port_serializer: sends a wide tagged word as a header beat plus LANE_W-bit data beats, LSB lane first.
// Defining TAGGED_PORT_SERIALIZER_PARITY_EN appends an even-parity beat to each frame.
module tagged_port_serializer #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 2,
    parameter int LANE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_data,
    output logic              out_first,
    output logic              out_last,
    output logic              busy
);
    localparam int BEATS = DATA_W / LANE_W;
    localparam int CW = $clog2(BEATS + 1);
    localparam int IW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
`ifdef TAGGED_PORT_SERIALIZER_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    if (DATA_W % LANE_W != 0) begin : g_bad_data_w
        $error("DATA_W must be a multiple of LANE_W");
    end
    if (TAG_W > LANE_W) begin : g_bad_tag_w
        $error("TAG_W must not exceed LANE_W");
    end

    typedef enum logic [1:0] {IDLE, HDR, DATA, PAR} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              out_valid_q, out_valid_d;
    logic [LANE_W-1:0] out_data_q, out_data_d;
    logic              out_first_q, out_first_d;
    logic              out_last_q, out_last_d;
    logic [CW-1:0]     nxt;
    logic [LANE_W-1:0] lanes [BEATS];
`ifdef TAGGED_PORT_SERIALIZER_PARITY_EN
    logic [TAG_W-1:0]  tag_q, tag_d;
`endif

    assign in_ready  = !rst && state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign nxt       = cnt_q + 1'b1;

    always_comb begin
        for (int i = 0; i < BEATS; i++) lanes[i] = data_q[i*LANE_W +: LANE_W];
    end

    // Outputs are computed one cycle ahead so every beat leaves straight from a flop.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
`ifdef TAGGED_PORT_SERIALIZER_PARITY_EN
        tag_d       = tag_q;
`endif
        case (state_q)
            IDLE: if (in_valid && in_ready) begin
                state_d     = HDR;
                cnt_d       = '0;
                data_d      = in_data;
                out_valid_d = 1'b1;
                out_first_d = 1'b1;
                out_last_d  = 1'b0;
                out_data_d  = LANE_W'(in_tag);
`ifdef TAGGED_PORT_SERIALIZER_PARITY_EN
                tag_d       = in_tag;
`endif
            end
            HDR: if (out_ready) begin
                state_d     = DATA;
                out_first_d = 1'b0;
                out_data_d  = lanes[0];
                out_last_d  = !PAR_EN && LAST == '0;
            end
            DATA: if (out_ready) begin
                if (cnt_q == LAST) begin
`ifdef TAGGED_PORT_SERIALIZER_PARITY_EN
                    state_d     = PAR;
                    out_data_d  = LANE_W'(^{tag_q, data_q});
                    out_last_d  = 1'b1;
`else
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    out_data_d  = '0;
`endif
                end else begin
                    cnt_d      = nxt;
                    out_data_d = lanes[nxt[IW-1:0]];
                    out_last_d = !PAR_EN && nxt == LAST;
                end
            end
            default: if (out_ready) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                out_data_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef TAGGED_PORT_SERIALIZER_PARITY_EN
            tag_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
`ifdef TAGGED_PORT_SERIALIZER_PARITY_EN
            tag_q       <= tag_d;
`endif
        end
    end
endmodule

// File: tb/tb_tagged_port_serializer.sv
// tb_tagged_port_serializer: directed beat-by-beat checks of tagged_port_serializer (DATA_W=32, TAG_W=2, LANE_W=8).
module tb_tagged_port_serializer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_tag;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_first;
    logic        out_last;
    logic        busy;
    int errors = 0;
    int checks = 0;
`ifdef TAGGED_PORT_SERIALIZER_PARITY_EN
    localparam logic LD = 1'b0;
`else
    localparam logic LD = 1'b1;
`endif

    tagged_port_serializer #(.DATA_W(32), .TAG_W(2), .LANE_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_tag(in_tag), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_first(out_first),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {valid, first, last, data}
    task automatic beat(input string tag, input logic [7:0] d, input logic f, input logic l);
        chk(tag, {5'b0, out_valid, out_first, out_last, out_data}, {5'b0, 1'b1, f, l, d});
    endtask

    task automatic idle(input string tag);
        chk(tag, {13'b0, out_valid, busy, in_ready}, {13'b0, 1'b0, 1'b0, 1'b1});
    endtask

    task automatic par_beat(input string tag, input logic p);
`ifdef TAGGED_PORT_SERIALIZER_PARITY_EN
        tick();
        beat(tag, {7'b0, p}, 1'b0, 1'b1);
`endif
    endtask

    task automatic accept(input logic [1:0] t, input logic [31:0] d);
        in_valid = 1'b1;
        in_tag   = t;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_tag = '0; in_data = '0; out_ready = 1'b0;
        #3;
        chk("reset_outputs", {10'b0, in_ready, out_valid, out_first, out_last, busy, 1'b0},
            16'h0000);
        chk("reset_data", {8'b0, out_data}, 16'h0000);
        tick();
        tick();
        rst = 1'b0;
        #1;
        idle("post_reset_idle");

        // 1: full-rate frame
        out_ready = 1'b1;
        accept(2'b10, 32'hA1B2C3D4);
        beat("t1_hdr", 8'h02, 1'b1, 1'b0);
        chk("t1_in_ready_busy", {14'b0, in_ready, busy}, 16'h0001);
        tick(); beat("t1_d0", 8'hD4, 1'b0, 1'b0);
        tick(); beat("t1_d1", 8'hC3, 1'b0, 1'b0);
        tick(); beat("t1_d2", 8'hB2, 1'b0, 1'b0);
        tick(); beat("t1_d3", 8'hA1, 1'b0, LD);
        chk("t1_in_ready_last", {15'b0, in_ready}, 16'h0000);
        par_beat("t1_par", 1'b0);
        tick(); idle("t1_gap");
        tick(); idle("t1_idle_out_ready_high");

        // 2: backpressure on C3
        accept(2'b10, 32'hA1B2C3D4);
        beat("t2_hdr", 8'h02, 1'b1, 1'b0);
        tick(); beat("t2_d0", 8'hD4, 1'b0, 1'b0);
        tick(); beat("t2_d1", 8'hC3, 1'b0, 1'b0);
        out_ready = 1'b0;
        tick(); beat("t2_hold0", 8'hC3, 1'b0, 1'b0);
        tick(); beat("t2_hold1", 8'hC3, 1'b0, 1'b0);
        tick(); beat("t2_hold2", 8'hC3, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick(); beat("t2_d2", 8'hB2, 1'b0, 1'b0);
        tick(); beat("t2_d3", 8'hA1, 1'b0, LD);
        par_beat("t2_par", 1'b0);
        tick(); idle("t2_gap");

        // 3: in_valid held high across two words
        in_valid = 1'b1; in_tag = 2'b01; in_data = 32'h11223344;
        tick(); beat("t3a_hdr", 8'h01, 1'b1, 1'b0);
        in_tag = 2'b11; in_data = 32'h55667788;
        tick(); beat("t3a_d0", 8'h44, 1'b0, 1'b0);
        tick(); beat("t3a_d1", 8'h33, 1'b0, 1'b0);
        tick(); beat("t3a_d2", 8'h22, 1'b0, 1'b0);
        tick(); beat("t3a_d3", 8'h11, 1'b0, LD);
        par_beat("t3a_par", 1'b1);
        tick(); idle("t3_gap");
        tick(); beat("t3b_hdr", 8'h03, 1'b1, 1'b0);
        in_valid = 1'b0;
        tick(); beat("t3b_d0", 8'h88, 1'b0, 1'b0);
        tick(); beat("t3b_d1", 8'h77, 1'b0, 1'b0);
        tick(); beat("t3b_d2", 8'h66, 1'b0, 1'b0);
        tick(); beat("t3b_d3", 8'h55, 1'b0, LD);
        par_beat("t3b_par", 1'b0);
        tick(); idle("t3b_gap");

        // 6: in_valid pulse while busy is ignored
        accept(2'b10, 32'h0F0F0F0F);
        beat("t6_hdr", 8'h02, 1'b1, 1'b0);
        tick(); beat("t6_d0", 8'h0F, 1'b0, 1'b0);
        in_valid = 1'b1; in_tag = 2'b11; in_data = 32'hFFFFFFFF;
        tick(); beat("t6_d1", 8'h0F, 1'b0, 1'b0);
        in_valid = 1'b0;
        chk("t6_busy", {15'b0, busy}, 16'h0001);
        tick(); beat("t6_d2", 8'h0F, 1'b0, 1'b0);
        tick(); beat("t6_d3", 8'h0F, 1'b0, LD);
        par_beat("t6_par", 1'b1);
        tick(); idle("t6_gap");

        // 4: reset mid-frame
        accept(2'b10, 32'hA1B2C3D4);
        beat("t4_hdr", 8'h02, 1'b1, 1'b0);
        tick(); beat("t4_d0", 8'hD4, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        chk("t4_abort", {12'b0, out_valid, out_last, busy, in_ready}, 16'h0000);
        tick();
        chk("t4_abort_held", {12'b0, out_valid, out_last, busy, in_ready}, 16'h0000);
        rst = 1'b0;
        #1;
        idle("t4_after_reset");
        accept(2'b01, 32'h00000000);
        beat("t4_hdr2", 8'h01, 1'b1, 1'b0);
        tick(); beat("t4_z0", 8'h00, 1'b0, 1'b0);
        tick(); beat("t4_z1", 8'h00, 1'b0, 1'b0);
        tick(); beat("t4_z2", 8'h00, 1'b0, 1'b0);
        tick(); beat("t4_z3", 8'h00, 1'b0, LD);
        par_beat("t4_par", 1'b1);
        tick(); idle("t4_gap");

`ifdef TAGGED_PORT_SERIALIZER_PARITY_EN
        // 5: parity beat values
        accept(2'b00, 32'h00000001);
        beat("t5a_hdr", 8'h00, 1'b1, 1'b0);
        tick(); beat("t5a_d0", 8'h01, 1'b0, 1'b0);
        tick(); tick();
        tick(); beat("t5a_d3", 8'h00, 1'b0, 1'b0);
        tick(); beat("t5a_par", 8'h01, 1'b0, 1'b1);
        tick(); idle("t5a_gap");
        accept(2'b11, 32'h00000000);
        beat("t5b_hdr", 8'h03, 1'b1, 1'b0);
        tick(); tick(); tick(); tick();
        beat("t5b_d3", 8'h00, 1'b0, 1'b0);
        tick(); beat("t5b_par", 8'h00, 1'b0, 1'b1);
        tick(); idle("t5b_gap");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
